// File: rtl/count_event_monitor.sv
// Checks a free-running counter for wrap, stall and jump events. Each event is
// timestamped and queued in a first-word-fall-through FIFO with a valid/ready output.
module count_event_monitor #(
   parameter int CNT_W       = 4,
   parameter int TS_W        = 12,
   parameter int FIFO_DEPTH  = 4,
   parameter int STALL_LIMIT = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [CNT_W-1:0]              count_in,
   input  logic                          count_en,
   input  logic                          clear,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [1:0]                    evt_type,
   output logic [CNT_W-1:0]              evt_value,
   output logic [TS_W-1:0]               evt_ts,
   output logic [7:0]                    wrap_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int SW = $clog2(STALL_LIMIT + 1);
   localparam int RW = 2 + CNT_W + TS_W;
   localparam logic [LW-1:0] DEPTH      = LW'(FIFO_DEPTH);
   localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_LIMIT);
   localparam logic [SW-1:0] STALL_FIRE = SW'(STALL_LIMIT - 1);
   localparam logic [1:0] EVT_WRAP  = 2'b01;
   localparam logic [1:0] EVT_STALL = 2'b10;
   localparam logic [1:0] EVT_JUMP  = 2'b11;

   logic [TS_W-1:0]  ts;
   logic [CNT_W-1:0] prev_count;
   logic [CNT_W-1:0] exp_count;
   logic             prev_en;
   logic             prev_valid;
   logic [SW-1:0]    stall_run;
   logic [SW-1:0]    stall_next;
   logic [RW-1:0]    mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    level;
   logic             det;
   logic [1:0]       det_type;
   logic             push;
   logic             pop;

   assign exp_count = prev_count + CNT_W'(1);

   always_comb begin
      det        = 1'b0;
      det_type   = 2'b00;
      stall_next = '0;
      if (prev_valid) begin
         if (prev_en) begin
            if (count_in == exp_count) begin
               if (&prev_count) begin
                  det      = 1'b1;
                  det_type = EVT_WRAP;
               end
            end else if (count_in == prev_count) begin
               stall_next = (stall_run == STALL_MAX) ? stall_run : stall_run + SW'(1);
               // Fires only on the transition into the limit, so once per run.
               if (stall_run == STALL_FIRE) begin
                  det      = 1'b1;
                  det_type = EVT_STALL;
               end
            end else begin
               det      = 1'b1;
               det_type = EVT_JUMP;
            end
         end else if (count_in != prev_count) begin
            det      = 1'b1;
            det_type = EVT_JUMP;
         end
      end
   end

   assign evt_valid  = (level != '0);
   assign pop        = evt_valid && evt_ready;
   assign push       = det && ((level < DEPTH) || pop);
   assign fifo_level = level;
   assign {evt_type, evt_value, evt_ts} = evt_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ts         <= '0;
         prev_count <= '0;
         prev_en    <= 1'b0;
         prev_valid <= 1'b0;
         stall_run  <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         wrap_count <= '0;
         overflow   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         prev_count <= count_in;
         prev_en    <= count_en;
         if (clear) begin
            ts         <= '0;
            prev_valid <= 1'b0;
            stall_run  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            wrap_count <= '0;
            overflow   <= 1'b0;
         end else begin
            ts         <= ts + TS_W'(1);
            prev_valid <= 1'b1;
            stall_run  <= stall_next;
            if (push) begin
               mem[wr_ptr] <= {det_type, count_in, ts};
               wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
            if (det && !push) overflow <= 1'b1;
            // The tally counts wraps even when the FIFO drops the record.
            if (det && (det_type == EVT_WRAP) && (wrap_count != 8'hFF))
               wrap_count <= wrap_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor: stimulus pushes expected events into a
// scoreboard queue and an independent monitor pops and compares on each handshake.
module tb_count_event_monitor;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  count_in = '0;
   logic        count_en = 1'b0;
   logic        clear = 1'b0;
   logic        evt_valid;
   logic        evt_ready = 1'b0;
   logic [1:0]  evt_type;
   logic [3:0]  evt_value;
   logic [11:0] evt_ts;
   logic [7:0]  wrap_count;
   logic [2:0]  fifo_level;
   logic        overflow;

   typedef struct packed {
      logic [1:0]  t;
      logic [3:0]  v;
      logic [11:0] ts;
   } evt_t;

   evt_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [11:0] tsm = '0;

   count_event_monitor dut (
      .clk        (clk),
      .reset      (reset),
      .count_in   (count_in),
      .count_en   (count_en),
      .clear      (clear),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_type   (evt_type),
      .evt_value  (evt_value),
      .evt_ts     (evt_ts),
      .wrap_count (wrap_count),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge; tsm tracks the DUT timestamp independently.
   task automatic tick();
      @(posedge clk);
      if (!reset || clear) tsm = '0;
      else tsm = tsm + 12'd1;
      #1;
   endtask

   task automatic drive(input logic [3:0] c, input logic en);
      count_in = c;
      count_en = en;
      tick();
   endtask

   task automatic expect_evt(input logic [1:0] t, input logic [3:0] v);
      evt_t e;
      e.t  = t;
      e.v  = v;
      e.ts = tsm;
      sb.push_back(e);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(evt_valid), 32'd0);
      chk({tag, "_type"},  32'(evt_type), 32'd0);
      chk({tag, "_value"}, 32'(evt_value), 32'd0);
      chk({tag, "_ts"},    32'(evt_ts), 32'd0);
      chk({tag, "_wrap"},  32'(wrap_count), 32'd0);
      chk({tag, "_level"}, 32'(fifo_level), 32'd0);
      chk({tag, "_ovf"},   32'(overflow), 32'd0);
   endtask

   // Monitor: compares every accepted head against the scoreboard.
   always @(negedge clk) begin
      if (reset && evt_valid && evt_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got type %0h value %0h ts %0h expected none",
                     evt_type, evt_value, evt_ts);
         end else begin
            evt_t e;
            e = sb.pop_front();
            chk("evt_type",  32'(evt_type),  32'(e.t));
            chk("evt_value", 32'(evt_value), 32'(e.v));
            chk("evt_ts",    32'(evt_ts),    32'(e.ts));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      tick();
      tick();
      chk_all_zero("reset");
      reset = 1'b1;

      // 1: full count sequence with one wrap
      evt_ready = 1'b1;
      for (int i = 0; i < 16; i++) drive(4'(i), 1'b1);
      expect_evt(2'b01, 4'd0);
      drive(4'd0, 1'b1);
      drive(4'd1, 1'b1);
      drive(4'd1, 1'b0);
      drive(4'd1, 1'b0);
      chk("t1_wrap_count", 32'(wrap_count), 32'd1);
      chk("t1_level", 32'(fifo_level), 32'd0);
      chk("t1_sb_drained", 32'(sb.size()), 32'd0);

      // 2: stall raised once on the third unchanged sample
      pulse_clear();
      drive(4'd4, 1'b1);
      drive(4'd5, 1'b1);
      drive(4'd5, 1'b1);
      drive(4'd5, 1'b1);
      expect_evt(2'b10, 4'd5);
      drive(4'd5, 1'b1);
      drive(4'd5, 1'b1);
      drive(4'd5, 1'b1);
      drive(4'd6, 1'b1);
      drive(4'd6, 1'b0);
      drive(4'd6, 1'b0);
      chk("t2_sb_drained", 32'(sb.size()), 32'd0);

      // 3: jumps with enable high and low
      pulse_clear();
      drive(4'd3, 1'b1);
      expect_evt(2'b11, 4'd9);
      drive(4'd9, 1'b1);
      pulse_clear();
      drive(4'd4, 1'b0);
      drive(4'd4, 1'b0);
      expect_evt(2'b11, 4'd7);
      drive(4'd7, 1'b0);
      drive(4'd7, 1'b0);
      drive(4'd7, 1'b0);
      chk("t3_sb_drained", 32'(sb.size()), 32'd0);
      chk("t3_wrap_count", 32'(wrap_count), 32'd0);

      // 4: overflow with consumer stalled
      pulse_clear();
      evt_ready = 1'b0;
      drive(4'd0, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         if (i <= 4) expect_evt(2'b11, 4'(i));
         drive(4'(i), 1'b0);
      end
      chk("t4_level_full", 32'(fifo_level), 32'd4);
      chk("t4_overflow", 32'(overflow), 32'd1);
      chk("t4_head_value", 32'(evt_value), 32'd1);
      evt_ready = 1'b1;
      for (int i = 0; i < 6; i++) drive(4'd6, 1'b0);
      chk("t4_level_empty", 32'(fifo_level), 32'd0);
      chk("t4_valid_low", 32'(evt_valid), 32'd0);
      chk("t4_overflow_sticky", 32'(overflow), 32'd1);
      chk("t4_sb_drained", 32'(sb.size()), 32'd0);
      pulse_clear();
      chk("t4_overflow_cleared", 32'(overflow), 32'd0);

      // 5: push and pop together while full
      evt_ready = 1'b0;
      drive(4'd0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         expect_evt(2'b11, 4'(i));
         drive(4'(i), 1'b0);
      end
      chk("t5_level_full", 32'(fifo_level), 32'd4);
      evt_ready = 1'b1;
      expect_evt(2'b11, 4'd5);
      drive(4'd5, 1'b0);
      chk("t5_level_kept", 32'(fifo_level), 32'd4);
      chk("t5_no_overflow", 32'(overflow), 32'd0);
      for (int i = 0; i < 6; i++) drive(4'd5, 1'b0);
      chk("t5_sb_drained", 32'(sb.size()), 32'd0);

      // 6: asynchronous reset mid-stream
      pulse_clear();
      evt_ready = 1'b0;
      drive(4'd0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         expect_evt(2'b11, 4'(i));
         drive(4'(i), 1'b0);
      end
      chk("t6_level", 32'(fifo_level), 32'd3);
      #2;
      reset = 1'b0;
      tsm = '0;
      sb.delete();
      #1;
      chk_all_zero("t6_async");
      tick();
      reset = 1'b1;
      evt_ready = 1'b1;
      drive(4'd9, 1'b1);
      expect_evt(2'b11, 4'd13);
      drive(4'd13, 1'b1);
      drive(4'd13, 1'b0);
      drive(4'd13, 1'b0);
      chk("t6_sb_drained", 32'(sb.size()), 32'd0);

      // 7: wrap tally saturates
      pulse_clear();
      for (int i = 0; i < 260; i++) begin
         if (i > 0) expect_evt(2'b11, 4'd15);
         drive(4'd15, 1'b1);
         expect_evt(2'b01, 4'd0);
         drive(4'd0, 1'b1);
      end
      drive(4'd0, 1'b0);
      drive(4'd0, 1'b0);
      drive(4'd0, 1'b0);
      chk("t7_wrap_sat", 32'(wrap_count), 32'd255);
      chk("t7_no_overflow", 32'(overflow), 32'd0);
      chk("t7_sb_drained", 32'(sb.size()), 32'd0);
      pulse_clear();
      chk("t7_wrap_cleared", 32'(wrap_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
- Downstream consumer of the 4-bit basic counter.
- Samples the counter value and the enable driven to it every cycle, and checks that the counter steps correctly.
- Classifies wrap, stall and jump events, timestamps each one and buffers it in a small first-word-fall-through FIFO with a valid/ready output.
- Feeds the simulation's logging and analysis stage, and also keeps a saturating wrap tally.

Parameters:
CNT_W, 4, width of the monitored count.
TS_W, 12, width of the free-running timestamp.
FIFO_DEPTH, 4, event FIFO entries; must be a power of 2, at least 2.
STALL_LIMIT, 3, consecutive unchanged enabled samples that raise a stall event; at least 1.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous active-low reset: 0 = reset asserted.
count_in  input  CNT_W  counter value.
count_en  input  1  enable currently driven to the counter.
clear  input  1  synchronous clear, one-cycle pulse.
evt_valid  output  1  FIFO head holds an event.
evt_ready  input  1  consumer accepts the head.
evt_type  output  2  01 wrap, 10 stall, 11 jump.
evt_value  output  CNT_W  count_in at detection.
evt_ts  output  TS_W  timestamp at detection.
wrap_count  output  8  saturating wrap tally.
fifo_level  output  clog2(FIFO_DEPTH)+1  occupied entries.
overflow  output  1  sticky: an event was dropped.

Behaviour:
- Reset: all outputs and internal state are 0 while reset=0, independent of clk. This includes prev_count, prev_en, prev_valid, stall_run, the FIFO pointers and ts.
- Timestamp: ts increments every cycle and wraps modulo 2^TS_W.
- Sampling: every rising edge registers prev_count<=count_in, prev_en<=count_en and prev_valid<=1.
- Detection window: detection is combinational on (prev_count, prev_en, count_in). It is suppressed while prev_valid=0, i.e. on the first cycle after reset or clear.
- Expected value: exp = prev_count+1 modulo 2^CNT_W.
- Rule, prev_en=1, count_in==exp: normal step. If prev_count is all-ones and count_in=0, raise a wrap event (01).
- Rule, prev_en=1, count_in==prev_count: stall_run increments, saturating at STALL_LIMIT. The stall event (10) fires only on the cycle stall_run reaches STALL_LIMIT, so once per stall run. Any change of count_in, or prev_en=0, clears stall_run.
- Rule, prev_en=1, any other value: raise a jump event (11).
- Rule, prev_en=0, count_in!=prev_count: raise a jump event (11).
- Rule, prev_en=0, count_in==prev_count: no event.
- Exclusivity: the rules are mutually exclusive, so there is at most one event per cycle.
- Event record: {type, count_in, ts at the detecting cycle}.
- Latency: the record is written on the detecting edge. evt_valid is high in the cycle following that edge when the FIFO was empty.
- wrap_count increments on every wrap event, even if the FIFO drops it, and saturates at 255.
- Pop: occurs when evt_valid && evt_ready.
- Push: occurs when an event is detected and (level<FIFO_DEPTH, or a pop happens in the same cycle).
- Push while full with no pop: the event is dropped, overflow is set, and the level is unchanged.
- Push and pop in the same cycle: the level is unchanged, including when full, and overflow is not set.
- Output stability: while evt_valid && !evt_ready, evt_type, evt_value and evt_ts hold stable.
- Empty: when the FIFO is empty, evt_valid=0 and the evt_* data fields drive 0.
- Ordering: events leave in strict FIFO order.
- clear: has priority over push, pop and detection that cycle. It empties the FIFO and zeroes wrap_count, overflow, ts, stall_run and prev_valid; prev_count and prev_en still sample.
- Reset mid-operation: outputs drop to 0 immediately. No event is raised on the first sample after deassertion.

Test Plan:
1. Reset, evt_ready=1, count_en=1, count_in steps 0..15,0,1 -> exactly one event: type 01, value 0, ts equal to the detecting cycle; wrap_count=1, with no jump or stall events.
2. count_en=1, count_in held at 5 for 6 cycles -> exactly one type-10 event with value 5, on the 3rd unchanged sample; no repeat. Then count_in=6 -> no event.
3. count_en=1, count_in 3 -> 9 -> one type-11 event with value 9. Separately, count_en=0 with count_in 4 -> 4 -> none; count_en=0 with 4 -> 7 -> one type-11 event with value 7.
4. evt_ready=0, inject 6 events -> fifo_level=4, overflow=1, and only the first 4 are retained in order. Then evt_ready=1 -> 4 pops in order, evt_valid falls, and overflow stays 1 until clear.
5. FIFO full with evt_ready=1 and an event injected in the same cycle -> fifo_level stays 4, overflow=0, and the new event appears 4th in order.
6. Assert reset=0 asynchronously mid-stream with level=3 -> all outputs 0 before the next edge. After release, a count jump on the first sample gives no event; the next step does.
